ringosc_freq_meter: RTL

- Downstream measurement stage for the ring oscillator. It drives the oscillator's enable and consumes its output.
- It gates the oscillator on, waits a settle interval, then counts oscillator rising edges over a fixed window of 2^GATE_LOG2 system clocks. It returns the edge count as a one-cycle-valid result.
- Measured frequency = count * f_clk / 2^GATE_LOG2. The oscillator must be prescaled or slow enough to stay below f_clk/2.

---
 rtl/ringosc_freq_meter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ringosc_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle, then
// counts synchronized rising edges over a 2^GATE_LOG2-cycle window.
`timescale 1ns/1ps

module ringosc_freq_meter #(
  parameter int GATE_LOG2  = 10,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         sync_q;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [GATE_LOG2-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]   edge_q, edge_d;
  logic               ovf_q, ovf_d;
  logic               osc_en_q, osc_en_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               count_valid_q, count_valid_d;
  logic               overflow_q, overflow_d;

  logic               rise;
  logic               settle_done;
  logic               gate_done;
  logic               edge_sat;
  logic [CNT_W-1:0]   edge_acc;
  logic               ovf_acc;

  // Two synchronizer flops plus a history flop; runs in every state.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], osc_in};
    end
  end

  assign rise        = sync_q[1] & ~sync_q[2];
  assign settle_done = (settle_q == SET_W'(SETTLE_CYC - 1));
  assign gate_done   = &gate_q;

  // Saturating edge accumulator; ovf records a rise lost at all-ones.
  assign edge_sat = &edge_q;
  assign edge_acc = (rise && !edge_sat) ? edge_q + 1'b1 : edge_q;
  assign ovf_acc  = ovf_q | (rise & edge_sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)       state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = MEASURE;
      MEASURE: if (gate_done)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    settle_d      = settle_q;
    gate_d        = gate_q;
    edge_d        = edge_q;
    ovf_d         = ovf_q;
    osc_en_d      = osc_en_q;
    busy_d        = busy_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    count_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          osc_en_d = 1'b1;
          busy_d   = 1'b1;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          gate_d = '0;
          edge_d = '0;
          ovf_d  = 1'b0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      MEASURE: begin
        edge_d = edge_acc;
        ovf_d  = ovf_acc;
        if (gate_done) begin
          // The final window cycle's rise is folded into the published result.
          count_d       = edge_acc;
          overflow_d    = ovf_acc;
          count_valid_d = 1'b1;
          osc_en_d      = 1'b0;
          busy_d        = 1'b0;
        end else begin
          gate_d = gate_q + 1'b1;
        end
      end
      default: begin
        osc_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q      <= '0;
      gate_q        <= '0;
      edge_q        <= '0;
      ovf_q         <= 1'b0;
      osc_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      settle_q      <= settle_d;
      gate_q        <= gate_d;
      edge_q        <= edge_d;
      ovf_q         <= ovf_d;
      osc_en_q      <= osc_en_d;
      busy_q        <= busy_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign osc_en      = osc_en_q;
  assign busy        = busy_q;
  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;

endmodule
